hazard_unit: RTL and testbench

//  Pipeline hazard controller for the 5-stage core; the consumer of the control unit's E/M/W

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/forward_select.sv | 34 +++
 rtl/hazard_unit.sv | 159 +++++++++++++++
 tb/tb_hazard_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
//   hz_state_t      : controller state (normal issue vs. waiting on data memory)
//   fwd_sel_t       : operand forwarding select as seen by the Execute-stage muxes
//   RESULT_SRC_LOAD : ResultSrcE encoding that marks a load in Execute
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/forward_select.sv
// Forwarding select for one Execute-stage source operand.
// Ports:
//   rsE       in  source register of the operand in Execute
//   rdM, rdW  in  destination registers of the M and W stage instructions
//   regWriteM in  M-stage instruction writes the register file
//   regWriteW in  W-stage instruction writes the register file
//   fwdSel    out FWD_M / FWD_W / FWD_RF
module forward_select
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rsE,
  input  logic [REG_ADDR_W-1:0] rdM,
  input  logic [REG_ADDR_W-1:0] rdW,
  input  logic                  regWriteM,
  input  logic                  regWriteW,
  output fwd_sel_t              fwdSel
);

  // x0 is hard-wired zero, so it is never forwarded. The M stage holds the
  // younger result, so it beats W when both match.
  always_comb begin
    fwdSel = FWD_RF;
    if (rsE != '0) begin
      if (regWriteM && (rdM == rsE)) begin
        fwdSel = FWD_M;
      end else if (regWriteW && (rdW == rsE)) begin
        fwdSel = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage core.
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   Rs1D, Rs2D          Decode source registers
//   Rs1E, Rs2E          Execute source registers
//   RdE, RdM, RdW       destination registers in E/M/W
//   ResultSrcE          2'b01 marks a load in Execute
//   RegWriteM/W         M/W instruction writes the register file
//   PCSrcE              taken branch/jump resolved in Execute
//   MemAccessM          load/store in Memory stage
//   MemReadyM           data memory completes the access this cycle
//   ForwardAE/BE        00 RF, 10 ALUResultM, 01 ResultW
//   StallF, StallD      hold PC / F-D register
//   FlushD, FlushE      clear F-D / D-E register
//   FreezeEMW           hold D-E, E-M and M-W registers
//   StallCount          saturating count of StallF cycles
//   FlushCount          saturating count of FlushE cycles
//   MemErr              sticky memory-wait timeout flag
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic [1:0]            ResultSrcE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  PCSrcE,
  input  logic                  MemAccessM,
  input  logic                  MemReadyM,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FreezeEMW,
  output logic [CNT_W-1:0]      StallCount,
  output logic [CNT_W-1:0]      FlushCount,
  output logic                  MemErr
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  hz_state_t         state, nextState;
  logic [WAIT_W-1:0] waitCount, waitNext;
  fwd_sel_t          fwdA, fwdB;
  logic              lwStall;

  forward_select #(.REG_ADDR_W(REG_ADDR_W)) uFwdA (
    .rsE(Rs1E), .rdM(RdM), .rdW(RdW),
    .regWriteM(RegWriteM), .regWriteW(RegWriteW), .fwdSel(fwdA)
  );

  forward_select #(.REG_ADDR_W(REG_ADDR_W)) uFwdB (
    .rsE(Rs2E), .rdM(RdM), .rdW(RdW),
    .regWriteM(RegWriteM), .regWriteW(RegWriteW), .fwdSel(fwdB)
  );

  // Forwarding is forced to the register file while reset is held so that
  // nothing downstream sees stale selects.
  assign ForwardAE = reset ? fwdA : FWD_RF;
  assign ForwardBE = reset ? fwdB : FWD_RF;

  assign lwStall = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != '0) &&
                   ((RdE == Rs1D) || (RdE == Rs2D));

  // Next-state and hazard outputs. A memory miss freezes the whole pipe and
  // takes priority over everything; in RUN a taken branch beats a load-use
  // stall because the Decode instruction is on the wrong path anyway. While
  // waiting, E is frozen, so PCSrcE is only acted on once back in RUN.
  always_comb begin
    nextState = state;
    waitNext  = waitCount;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FreezeEMW = 1'b0;
    case (state)
      RUN: begin
        waitNext = '0;
        if (MemAccessM && !MemReadyM) begin
          StallF    = 1'b1;
          StallD    = 1'b1;
          FreezeEMW = 1'b1;
          nextState = MEM_WAIT;
          waitNext  = WAIT_W'(1);
        end else if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (lwStall) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
      MEM_WAIT: begin
        StallF    = 1'b1;
        StallD    = 1'b1;
        FreezeEMW = 1'b1;
        if (MemReadyM) begin
          nextState = RUN;
          waitNext  = '0;
        end else if (waitCount != WAIT_LIMIT) begin
          waitNext = waitCount + WAIT_W'(1);
        end
      end
      default: begin
        nextState = RUN;
        waitNext  = '0;
      end
    endcase
    if (!reset) begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FreezeEMW = 1'b0;
    end
  end

  // State, wait counter, sticky timeout flag and saturating performance
  // counters. MemErr rises on the same edge the wait counter reaches the
  // limit and only reset clears it; the wait itself continues regardless.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      waitCount  <= '0;
      MemErr     <= 1'b0;
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      state     <= nextState;
      waitCount <= waitNext;
      if ((nextState == MEM_WAIT) && (waitNext == WAIT_LIMIT)) begin
        MemErr <= 1'b1;
      end
      if (StallF && (StallCount != '1)) begin
        StallCount <= StallCount + CNT_W'(1);
      end
      if (FlushE && (FlushCount != '1)) begin
        FlushCount <= FlushCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed testbench for hazard_unit, built with MEM_TIMEOUT=4.
module tb_hazard_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]  ResultSrcE;
  logic        RegWriteM, RegWriteW, PCSrcE, MemAccessM, MemReadyM;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, FlushD, FlushE, FreezeEMW, MemErr;
  logic [15:0] StallCount, FlushCount;

  int checks = 0;
  int passed = 0;

  hazard_unit #(.REG_ADDR_W(5), .CNT_W(16), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .FreezeEMW(FreezeEMW), .StallCount(StallCount), .FlushCount(FlushCount),
    .MemErr(MemErr)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyIdle();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE = 2'b00;
    RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
    MemAccessM = 1'b0; MemReadyM = 1'b0;
  endtask

  task automatic doReset();
    applyIdle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    applyIdle();
    Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
    Rs2E = 5'd3; RdW = 5'd3; RegWriteW = 1'b1;
    PCSrcE = 1'b1; MemAccessM = 1'b1;
    reset = 1'b0;
    #1;
    checks++; if (ForwardAE !== 2'b00) $display("[TB] FAIL reset_fwdA got %b want 00", ForwardAE); else passed++;
    checks++; if (ForwardBE !== 2'b00) $display("[TB] FAIL reset_fwdB got %b want 00", ForwardBE); else passed++;
    checks++; if (FlushE !== 1'b0) $display("[TB] FAIL reset_flushE got %b want 0", FlushE); else passed++;
    checks++; if (FlushD !== 1'b0) $display("[TB] FAIL reset_flushD got %b want 0", FlushD); else passed++;
    checks++; if (StallF !== 1'b0) $display("[TB] FAIL reset_stallF got %b want 0", StallF); else passed++;
    checks++; if (FreezeEMW !== 1'b0) $display("[TB] FAIL reset_freeze got %b want 0", FreezeEMW); else passed++;
    @(posedge clk); #1;
    checks++; if (StallCount !== 16'd0) $display("[TB] FAIL reset_stallCnt got %0d want 0", StallCount); else passed++;
    checks++; if (MemErr !== 1'b0) $display("[TB] FAIL reset_memErr got %b want 0", MemErr); else passed++;
    applyIdle();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_forwarding();
    @(posedge clk); #1;
    applyIdle();
    Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1;
    #1;
    checks++; if (ForwardAE !== 2'b10) $display("[TB] FAIL fwd_M_priority got %b want 10", ForwardAE); else passed++;
    RegWriteM = 1'b0;
    #1;
    checks++; if (ForwardAE !== 2'b01) $display("[TB] FAIL fwd_W got %b want 01", ForwardAE); else passed++;
    Rs2E = 5'd0; RdM = 5'd0; RegWriteM = 1'b1;
    #1;
    checks++; if (ForwardBE !== 2'b00) $display("[TB] FAIL fwd_x0 got %b want 00", ForwardBE); else passed++;
    Rs2E = 5'd9; RdW = 5'd9; RegWriteW = 1'b1; RdM = 5'd3;
    #1;
    checks++; if (ForwardBE !== 2'b01) $display("[TB] FAIL fwdB_W got %b want 01", ForwardBE); else passed++;
    applyIdle();
  endtask

  task automatic test_load_use();
    doReset();
    @(posedge clk); #1;
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    #1;
    checks++; if (StallF !== 1'b1) $display("[TB] FAIL lw_stallF got %b want 1", StallF); else passed++;
    checks++; if (StallD !== 1'b1) $display("[TB] FAIL lw_stallD got %b want 1", StallD); else passed++;
    checks++; if (FlushE !== 1'b1) $display("[TB] FAIL lw_flushE got %b want 1", FlushE); else passed++;
    checks++; if (FlushD !== 1'b0) $display("[TB] FAIL lw_flushD got %b want 0", FlushD); else passed++;
    @(posedge clk); #1;
    applyIdle();
    #1;
    checks++; if (StallF !== 1'b0) $display("[TB] FAIL lw_release got %b want 0", StallF); else passed++;
    checks++; if (StallCount !== 16'd1) $display("[TB] FAIL lw_stallCnt got %0d want 1", StallCount); else passed++;
    checks++; if (FlushCount !== 16'd1) $display("[TB] FAIL lw_flushCnt got %0d want 1", FlushCount); else passed++;
    ResultSrcE = 2'b01; RdE = 5'd0; Rs1D = 5'd0;
    #1;
    checks++; if (StallF !== 1'b0) $display("[TB] FAIL lw_x0 got %b want 0", StallF); else passed++;
    ResultSrcE = 2'b00; RdE = 5'd7; Rs1D = 5'd7;
    #1;
    checks++; if (StallF !== 1'b0) $display("[TB] FAIL lw_notload got %b want 0", StallF); else passed++;
    applyIdle();
  endtask

  task automatic test_flush_priority();
    @(posedge clk); #1;
    ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7; PCSrcE = 1'b1;
    #1;
    checks++; if (FlushD !== 1'b1) $display("[TB] FAIL prio_flushD got %b want 1", FlushD); else passed++;
    checks++; if (FlushE !== 1'b1) $display("[TB] FAIL prio_flushE got %b want 1", FlushE); else passed++;
    checks++; if (StallF !== 1'b0) $display("[TB] FAIL prio_stallF got %b want 0", StallF); else passed++;
    checks++; if (StallD !== 1'b0) $display("[TB] FAIL prio_stallD got %b want 0", StallD); else passed++;
    applyIdle();
  endtask

  task automatic test_mem_freeze();
    doReset();
    @(posedge clk); #1;
    PCSrcE = 1'b1; MemAccessM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) MemReadyM = 1'b1;
      #1;
      checks++; if (FreezeEMW !== 1'b1) $display("[TB] FAIL freeze_c%0d got %b want 1", i, FreezeEMW); else passed++;
      checks++; if (FlushE !== 1'b0) $display("[TB] FAIL freeze_flushE_c%0d got %b want 0", i, FlushE); else passed++;
      checks++; if (StallF !== 1'b1) $display("[TB] FAIL freeze_stallF_c%0d got %b want 1", i, StallF); else passed++;
      @(posedge clk); #1;
    end
    MemAccessM = 1'b0; MemReadyM = 1'b0;
    #1;
    checks++; if (FreezeEMW !== 1'b0) $display("[TB] FAIL freeze_release got %b want 0", FreezeEMW); else passed++;
    checks++; if (FlushE !== 1'b1) $display("[TB] FAIL freeze_pending_flush got %b want 1", FlushE); else passed++;
    checks++; if (StallCount !== 16'd4) $display("[TB] FAIL freeze_stallCnt got %0d want 4", StallCount); else passed++;
    checks++; if (FlushCount !== 16'd0) $display("[TB] FAIL freeze_flushCnt got %0d want 0", FlushCount); else passed++;
    @(posedge clk); #1;
    checks++; if (FlushCount !== 16'd1) $display("[TB] FAIL freeze_flushCnt2 got %0d want 1", FlushCount); else passed++;
    applyIdle();
  endtask

  task automatic test_timeout();
    doReset();
    @(posedge clk); #1;
    MemAccessM = 1'b1; MemReadyM = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      if (e == 2 || e == 3) begin
        checks++; if (MemErr !== 1'b0) $display("[TB] FAIL timeout_early_e%0d got %b want 0", e, MemErr); else passed++;
      end
      if (e >= 5) begin
        checks++; if (MemErr !== 1'b1) $display("[TB] FAIL timeout_set_e%0d got %b want 1", e, MemErr); else passed++;
      end
    end
    checks++; if (FreezeEMW !== 1'b1) $display("[TB] FAIL timeout_still_waiting got %b want 1", FreezeEMW); else passed++;
    MemReadyM = 1'b1;
    @(posedge clk); #1;
    MemAccessM = 1'b0; MemReadyM = 1'b0;
    #1;
    checks++; if (FreezeEMW !== 1'b0) $display("[TB] FAIL timeout_release got %b want 0", FreezeEMW); else passed++;
    checks++; if (MemErr !== 1'b1) $display("[TB] FAIL timeout_sticky got %b want 1", MemErr); else passed++;
    applyIdle();
  endtask

  task automatic test_reset_mid_wait();
    doReset();
    @(posedge clk); #1;
    MemAccessM = 1'b1; MemReadyM = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (MemErr !== 1'b1) $display("[TB] FAIL midwait_pre_err got %b want 1", MemErr); else passed++;
    checks++; if (FreezeEMW !== 1'b1) $display("[TB] FAIL midwait_pre_freeze got %b want 1", FreezeEMW); else passed++;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (FreezeEMW !== 1'b0) $display("[TB] FAIL midwait_freeze got %b want 0", FreezeEMW); else passed++;
    checks++; if (StallF !== 1'b0) $display("[TB] FAIL midwait_stallF got %b want 0", StallF); else passed++;
    checks++; if (MemErr !== 1'b0) $display("[TB] FAIL midwait_memErr got %b want 0", MemErr); else passed++;
    checks++; if (StallCount !== 16'd0) $display("[TB] FAIL midwait_stallCnt got %0d want 0", StallCount); else passed++;
    applyIdle();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (FreezeEMW !== 1'b0) $display("[TB] FAIL midwait_run got %b want 0", FreezeEMW); else passed++;
    checks++; if (FlushE !== 1'b0) $display("[TB] FAIL midwait_no_flush got %b want 0", FlushE); else passed++;
  endtask

  initial begin
    applyIdle();
    reset = 1'b1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_flush_priority();
    test_mem_freeze();
    test_timeout();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
